// File: rtl/exhaustive_sweep_engine.sv
// Exhaustive stimulus sequencer: walks all 2^IN_W input vectors in binary or Gray order,
// captures each DUT response onto a valid/ready log stream and folds every pair into a MISR.
`timescale 1ns/1ps
module exhaustive_sweep_engine #(
  parameter int          IN_W       = 5,
  parameter int          OUT_W      = 1,
  parameter int          SETTLE_CYC = 1,
  parameter int          SIG_W      = 16,
  parameter logic [31:0] POLY       = 32'h1021
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             gray_mode,
  input  logic             abort,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             log_valid,
  input  logic             log_ready,
  output logic [IN_W-1:0]  log_pattern,
  output logic [OUT_W-1:0] log_response,
  output logic             busy,
  output logic             done,
  output logic [IN_W:0]    vec_count,
  output logic [SIG_W-1:0] signature
);

  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE} state_t;

  localparam int                CNT_W       = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [IN_W-1:0]   LAST_IDX    = '1;
  localparam logic [SIG_W-1:0]  POLY_W      = POLY[SIG_W-1:0];

  state_t             state_q;
  logic [IN_W-1:0]    index_q;
  logic [CNT_W-1:0]   settle_q;
  logic               gray_q;
  logic [IN_W-1:0]    dut_in_q;
  logic               log_valid_q;
  logic [IN_W-1:0]    log_pattern_q;
  logic [OUT_W-1:0]   log_response_q;
  logic               busy_q;
  logic               done_q;
  logic [IN_W:0]      vec_count_q;
  logic [SIG_W-1:0]   sig_q;

  logic [IN_W-1:0]    index_d;
  logic [SIG_W-1:0]   sig_d;
  logic [SIG_W-1:0]   pair_word;

  function automatic logic [IN_W-1:0] map_index(input logic [IN_W-1:0] idx, input logic gray);
    return gray ? (idx ^ (idx >> 1)) : idx;
  endfunction

  assign index_d   = index_q + IN_W'(1);
  assign pair_word = SIG_W'({log_pattern_q, log_response_q});
  assign sig_d     = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY_W : '0) ^ pair_word;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      index_q        <= '0;
      settle_q       <= '0;
      gray_q         <= 1'b0;
      dut_in_q       <= '0;
      log_valid_q    <= 1'b0;
      log_pattern_q  <= '0;
      log_response_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      vec_count_q    <= '0;
      sig_q          <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            index_q     <= '0;
            settle_q    <= '0;
            gray_q      <= gray_mode;
            dut_in_q    <= '0;
            vec_count_q <= '0;
            sig_q       <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= APPLY;
          end
        end
        APPLY: begin
          if (abort) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            log_valid_q <= 1'b0;
            dut_in_q    <= '0;
          end else if (settle_q == SETTLE_LAST) begin
            log_response_q <= dut_out;
            log_pattern_q  <= dut_in_q;
            log_valid_q    <= 1'b1;
            state_q        <= CAPTURE;
          end else begin
            settle_q <= settle_q + CNT_W'(1);
          end
        end
        CAPTURE: begin
          if (abort) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            log_valid_q <= 1'b0;
            dut_in_q    <= '0;
          end else if (log_ready) begin
            log_valid_q <= 1'b0;
            vec_count_q <= vec_count_q + (IN_W+1)'(1);
            sig_q       <= sig_d;
            // The last vector ends the sweep instead of wrapping the index.
            if (index_q == LAST_IDX) begin
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              dut_in_q <= '0;
            end else begin
              index_q  <= index_d;
              dut_in_q <= map_index(index_d, gray_q);
              settle_q <= '0;
              state_q  <= APPLY;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dut_in       = dut_in_q;
  assign log_valid    = log_valid_q;
  assign log_pattern  = log_pattern_q;
  assign log_response = log_response_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign vec_count    = vec_count_q;
  assign signature    = sig_q;

endmodule

// File: tb/tb_exhaustive_sweep_engine.sv
// Directed bench for exhaustive_sweep_engine: binary/Gray sweeps, MISR, settle timing,
// backpressure, abort and asynchronous reset.
`timescale 1ns/1ps
module tb_exhaustive_sweep_engine;

  logic        ck = 1'b0;
  logic        rst, start, gray_mode, abort, log_ready, use_reg;
  logic [4:0]  dut_in, log_pattern;
  logic        dut_out, log_response, log_valid, busy, done;
  logic [5:0]  vec_count;
  logic [15:0] signature;
  logic        pipe1, pipe2;

  logic        s3_start, s3_gray, s3_abort, s3_ready;
  logic [4:0]  s3_dut_in, s3_log_pattern;
  logic        s3_dut_out, s3_log_response, s3_log_valid, s3_busy, s3_done;
  logic [5:0]  s3_vec_count;
  logic [15:0] s3_signature;
  logic        s3_pipe1, s3_pipe2;

  int          passed = 0;
  int          total  = 0;
  logic [4:0]  obs_pat [32];
  logic [15:0] obs_sig [32];
  int          cyc, acc, pat_err, resp_err, stall_cnt, stall_bad;
  logic [15:0] model_sig;

  always #5 ck = ~ck;

  // Two-cycle registered parity DUTs.
  always @(posedge ck or posedge rst)
    if (rst) begin pipe1 <= 1'b0; pipe2 <= 1'b0; end
    else begin pipe1 <= ^dut_in; pipe2 <= pipe1; end
  always @(posedge ck or posedge rst)
    if (rst) begin s3_pipe1 <= 1'b0; s3_pipe2 <= 1'b0; end
    else begin s3_pipe1 <= ^s3_dut_in; s3_pipe2 <= s3_pipe1; end

  assign dut_out    = use_reg ? pipe2 : ^dut_in;
  assign s3_dut_out = s3_pipe2;

  exhaustive_sweep_engine u_dut (
    .CK(ck), .reset(rst), .start(start), .gray_mode(gray_mode), .abort(abort),
    .dut_in(dut_in), .dut_out(dut_out), .log_valid(log_valid), .log_ready(log_ready),
    .log_pattern(log_pattern), .log_response(log_response), .busy(busy), .done(done),
    .vec_count(vec_count), .signature(signature)
  );

  exhaustive_sweep_engine #(.SETTLE_CYC(3)) u_s3 (
    .CK(ck), .reset(rst), .start(s3_start), .gray_mode(s3_gray), .abort(s3_abort),
    .dut_in(s3_dut_in), .dut_out(s3_dut_out), .log_valid(s3_log_valid), .log_ready(s3_ready),
    .log_pattern(s3_log_pattern), .log_response(s3_log_response), .busy(s3_busy), .done(s3_done),
    .vec_count(s3_vec_count), .signature(s3_signature)
  );

  function automatic logic [4:0] exp_map(input int i, input bit g);
    logic [4:0] v;
    v = 5'(i);
    return g ? (v ^ (v >> 1)) : v;
  endfunction

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [4:0] p, input logic r);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {10'b0, p, r};
  endfunction

  // Runs one full sweep on u_dut, stalling log_ready for stall_len cycles at vector stall_vec.
  task automatic run_sweep(input bit gray, input int stall_vec, input int stall_len);
    bit         pending;
    logic [4:0] ep;
    logic       er;
    model_sig = '0; acc = 0; pat_err = 0; resp_err = 0; cyc = 0;
    stall_cnt = 0; stall_bad = 0; pending = 0;
    gray_mode = gray; log_ready = 1'b1;
    @(negedge ck); start = 1'b1;
    @(negedge ck); start = 1'b0;
    while (cyc < 500) begin
      if (pending) begin
        if (acc <= 32) obs_sig[acc-1] = signature;
        pending = 0;
      end
      if (done) break;
      if (acc == stall_vec && stall_cnt > 0)
        if (log_valid !== 1'b1 || log_pattern !== exp_map(stall_vec, gray) ||
            dut_in !== exp_map(stall_vec, gray))
          stall_bad++;
      if (log_valid && acc == stall_vec && stall_cnt < stall_len) begin
        log_ready = 1'b0;
        stall_cnt++;
      end else begin
        log_ready = 1'b1;
      end
      if (log_valid && log_ready) begin
        ep = exp_map(acc, gray);
        er = ^ep;
        if (acc < 32) obs_pat[acc] = log_pattern;
        if (log_pattern !== ep) pat_err++;
        if (log_response !== er) resp_err++;
        model_sig = misr(model_sig, ep, er);
        acc++;
        pending = 1;
      end
      @(negedge ck); cyc++;
    end
    log_ready = 1'b1;
    if (!done) begin
      total++;
      $display("FAIL sweep_timeout: done=%b after %0d cycles, required 1", done, cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; gray_mode = 1'b0; abort = 1'b0; log_ready = 1'b1; use_reg = 1'b0;
    s3_start = 1'b0; s3_gray = 1'b0; s3_abort = 1'b0; s3_ready = 1'b1;
    repeat (2) @(negedge ck);
    total++;
    if ({dut_in, log_valid, log_pattern, log_response, busy, done, vec_count, signature} !== '0)
      $display("FAIL reset_outputs: got dut_in=%h lv=%b lp=%h lr=%b busy=%b done=%b vc=%0d sig=%h, required all 0",
               dut_in, log_valid, log_pattern, log_response, busy, done, vec_count, signature);
    else passed++;
    rst = 1'b0;
    @(negedge ck);
    total++;
    if (busy !== 1'b0 || dut_in !== 5'd0) $display("FAIL idle_after_reset: busy=%b dut_in=%h, required 0/0", busy, dut_in);
    else passed++;
  endtask

  task automatic test_binary_sweep();
    run_sweep(1'b0, -1, 0);
    total++; if (cyc !== 64) $display("FAIL bin_cycles: got %0d, required 64", cyc); else passed++;
    total++; if (vec_count !== 6'd32) $display("FAIL bin_vec_count: got %0d, required 32", vec_count); else passed++;
    total++; if (pat_err !== 0 || resp_err !== 0) $display("FAIL bin_pairs: pattern errors %0d response errors %0d, required 0", pat_err, resp_err); else passed++;
    total++; if (obs_sig[0] !== 16'h0000) $display("FAIL sig_v0: got %h, required 0000", obs_sig[0]); else passed++;
    total++; if (obs_sig[1] !== 16'h0003) $display("FAIL sig_v1: got %h, required 0003", obs_sig[1]); else passed++;
    total++; if (obs_sig[2] !== 16'h0003) $display("FAIL sig_v2: got %h, required 0003", obs_sig[2]); else passed++;
    total++; if (obs_sig[3] !== 16'h0000) $display("FAIL sig_v3: got %h, required 0000", obs_sig[3]); else passed++;
    total++; if (signature !== model_sig) $display("FAIL bin_final_sig: got %h, required %h", signature, model_sig); else passed++;
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || dut_in !== 5'd0 || log_valid !== 1'b0)
      $display("FAIL bin_end_state: done=%b busy=%b dut_in=%h lv=%b, required 1/0/00/0", done, busy, dut_in, log_valid);
    else passed++;
  endtask

  task automatic test_gray_sweep();
    logic [4:0] first [5];
    int         seen  [32];
    int         bad;
    first[0] = 5'b00000; first[1] = 5'b00001; first[2] = 5'b00011; first[3] = 5'b00010; first[4] = 5'b00110;
    run_sweep(1'b1, -1, 0);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (obs_pat[i] !== first[i]) $display("FAIL gray_pat%0d: got %b, required %b", i, obs_pat[i], first[i]);
      else passed++;
    end
    for (int i = 0; i < 32; i++) seen[i] = 0;
    for (int i = 0; i < 32; i++) if (!$isunknown(obs_pat[i])) seen[obs_pat[i]]++;
    bad = 0;
    for (int i = 0; i < 32; i++) if (seen[i] != 1) bad++;
    total++; if (bad !== 0 || acc !== 32) $display("FAIL gray_unique: %0d patterns not seen once, %0d pairs, required 0/32", bad, acc); else passed++;
    total++; if (signature !== model_sig) $display("FAIL gray_sig: got %h, required %h", signature, model_sig); else passed++;
  endtask

  task automatic test_settle();
    int c, a, rerr, perr;
    c = 0; a = 0; rerr = 0; perr = 0;
    @(negedge ck); s3_start = 1'b1;
    @(negedge ck); s3_start = 1'b0;
    while (!s3_done && c < 1000) begin
      if (s3_log_valid) begin
        if (s3_log_pattern !== exp_map(a, 1'b0)) perr++;
        if (s3_log_response !== ^exp_map(a, 1'b0)) rerr++;
        a++;
      end
      @(negedge ck); c++;
    end
    total++; if (rerr !== 0 || perr !== 0) $display("FAIL settle3_resp: response errors %0d pattern errors %0d, required 0", rerr, perr); else passed++;
    total++; if (a !== 32 || s3_vec_count !== 6'd32) $display("FAIL settle3_count: pairs %0d vc %0d, required 32", a, s3_vec_count); else passed++;
    total++; if (c !== 128) $display("FAIL settle3_cycles: got %0d, required 128", c); else passed++;
    use_reg = 1'b1;
    run_sweep(1'b0, -1, 0);
    use_reg = 1'b0;
    total++; if (resp_err == 0) $display("FAIL settle1_regdut: got %0d response mismatches, required >0", resp_err); else passed++;
  endtask

  task automatic test_backpressure();
    run_sweep(1'b0, 5, 3);
    total++; if (cyc !== 67) $display("FAIL bp_cycles: got %0d, required 67", cyc); else passed++;
    total++; if (stall_cnt !== 3 || stall_bad !== 0) $display("FAIL bp_hold: stalls %0d unstable cycles %0d, required 3/0", stall_cnt, stall_bad); else passed++;
    total++; if (vec_count !== 6'd32 || signature !== model_sig) $display("FAIL bp_result: vc %0d sig %h, required 32 %h", vec_count, signature, model_sig); else passed++;
  endtask

  task automatic test_abort();
    int          c;
    logic [15:0] s;
    logic [4:0]  p;
    gray_mode = 1'b0; log_ready = 1'b1;
    @(negedge ck); start = 1'b1;
    @(negedge ck); start = 1'b0;
    c = 0;
    while (vec_count !== 6'd10 && c < 200) begin @(negedge ck); c++; end
    total++; if (dut_in !== 5'd10 || log_valid !== 1'b0) $display("FAIL abort_setup: dut_in %0d lv %b, required 10/0", dut_in, log_valid); else passed++;
    abort = 1'b1;
    @(negedge ck); abort = 1'b0;
    s = '0;
    for (int k = 0; k < 10; k++) begin p = 5'(k); s = misr(s, p, ^p); end
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || vec_count !== 6'd10 || dut_in !== 5'd0 || log_valid !== 1'b0)
      $display("FAIL abort_state: busy=%b done=%b vc=%0d dut_in=%0d lv=%b, required 0/0/10/0/0", busy, done, vec_count, dut_in, log_valid);
    else passed++;
    total++; if (signature !== s) $display("FAIL abort_sig: got %h, required %h", signature, s); else passed++;
    start = 1'b1; abort = 1'b1;
    @(negedge ck); start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0 || vec_count !== 6'd10) $display("FAIL start_abort_idle: busy=%b vc=%0d, required 0/10", busy, vec_count); else passed++;
    run_sweep(1'b0, -1, 0);
    total++;
    if (pat_err !== 0 || cyc !== 64 || vec_count !== 6'd32 || signature !== model_sig)
      $display("FAIL resweep: pattern errors %0d cycles %0d vc %0d sig %h, required 0/64/32/%h", pat_err, cyc, vec_count, signature, model_sig);
    else passed++;
  endtask

  task automatic test_busy_start_and_reset();
    int c;
    gray_mode = 1'b0; log_ready = 1'b1;
    @(negedge ck); start = 1'b1;
    @(negedge ck); start = 1'b0;
    c = 0;
    while (vec_count !== 6'd3 && c < 200) begin @(negedge ck); c++; end
    start = 1'b1;
    @(negedge ck); start = 1'b0;
    total++;
    if (dut_in !== 5'd3 || vec_count !== 6'd3 || busy !== 1'b1)
      $display("FAIL start_while_busy: dut_in=%0d vc=%0d busy=%b, required 3/3/1", dut_in, vec_count, busy);
    else passed++;
    c = 0;
    log_ready = 1'b0;
    while (log_valid !== 1'b1 && c < 20) begin @(negedge ck); c++; end
    @(negedge ck);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({dut_in, log_valid, log_pattern, log_response, busy, done, vec_count, signature} !== '0)
      $display("FAIL async_reset: dut_in=%h lv=%b lp=%h lr=%b busy=%b done=%b vc=%0d sig=%h, required all 0",
               dut_in, log_valid, log_pattern, log_response, busy, done, vec_count, signature);
    else passed++;
    @(negedge ck); rst = 1'b0; log_ready = 1'b1;
    repeat (2) @(negedge ck);
    total++; if (busy !== 1'b0 || dut_in !== 5'd0) $display("FAIL no_restart: busy=%b dut_in=%0d, required 0/0", busy, dut_in); else passed++;
  endtask

  initial begin
    test_reset();
    test_binary_sweep();
    test_gray_sweep();
    test_settle();
    test_backpressure();
    test_abort();
    test_busy_start_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/exhaustive_sweep_engine.md
# exhaustive_sweep_engine

Synthesizable, parametrised exhaustive stimulus sequencer with response capture for the trojan-detection test harness. It walks every input vector of an IN_W-bit combinational or sequential DUT in binary or Gray order, holds each vector for a programmable settle time, and samples the DUT output. Each (pattern, response) pair goes out on a valid/ready log stream, so a slow logger can apply backpressure. A MISR signature of all pairs gives a one-word golden comparison.

## Interface
- IN_W, 5, DUT input width (1..16); sweep length is 2^IN_W vectors.
- OUT_W, 1, DUT output width (1..16).
- SETTLE_CYC, 1, cycles each vector is held before sampling (>=1).
- SIG_W, 16, MISR width; IN_W+OUT_W <= SIG_W is required.
- POLY, 16'h1021, MISR feedback polynomial (low SIG_W bits used).

Ports:
- CK  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  begins a sweep when sampled high in IDLE.
- gray_mode  in  1  0 = binary order, 1 = Gray order; latched at start.
- abort  in  1  terminates the sweep; has priority over everything except reset.
- dut_in  out  IN_W  vector applied to the DUT.
- dut_out  in  OUT_W  DUT response.
- log_valid  out  1  pair available.
- log_ready  in  1  logger accepts pair.
- log_pattern  out  IN_W  pattern of the current pair.
- log_response  out  OUT_W  sampled response.
- busy  out  1  sweep in progress.
- done  out  1  sweep completed; sticky until next start or reset.
- vec_count  out  IN_W+1  accepted pairs in the current or last sweep.
- signature  out  SIG_W  MISR value.

## Operation
- Reset: state IDLE, index 0, all outputs 0 (dut_in, log_*, busy, done, vec_count, signature).
- States: IDLE, APPLY, CAPTURE.
- Pattern map: binary = index; Gray = index ^ (index >> 1). dut_in always equals the map of the current index. dut_in returns to 0 in IDLE.
- IDLE + start: index=0, vec_count=0, signature=0, done=0, mode latched, settle counter=0 -> APPLY. busy=1.
- APPLY: counts SETTLE_CYC cycles. On the final count edge, dut_out is registered into log_response and dut_in into log_pattern -> CAPTURE.
- CAPTURE: log_valid=1. log_pattern, log_response and dut_in are held stable until log_ready is high on a clock edge.
- Handshake (log_valid & log_ready):
  - vec_count increments.
  - signature updates to ((sig<<1) ^ (sig[SIG_W-1] ? POLY : 0)) ^ D, where D = {log_pattern, log_response} zero-extended to SIG_W.
  - If index == 2^IN_W-1: go to IDLE with done=1 and busy=0.
  - Otherwise: index+1, go to APPLY.
- start while busy: ignored. start and abort high together in IDLE: abort wins, so no sweep starts.
- abort while busy: next edge goes to IDLE with busy=0, log_valid=0, done=0, dut_in=0. vec_count and signature freeze at their partial values.
- Index wrap: index never wraps; the sweep ends after the last vector. IN_W=16 yields vec_count 65536 in 17 bits.
- Reset mid-sweep: immediate return to reset values, with no partial log transfer.

## Timing
- start edge to first dut_in = pattern 0: same edge (registered output, visible the following cycle).
- Per vector with log_ready held 1: SETTLE_CYC + 1 cycles. Full sweep: 2^IN_W*(SETTLE_CYC+1) cycles from the start edge to done=1.
- Each cycle log_ready is low in CAPTURE adds one cycle, with all log outputs and dut_in unchanged.
- dut_out is sampled exactly SETTLE_CYC edges after dut_in changes.
- done rises on the same edge that busy falls.

## Test plan
- Defaults, dut_out = ^dut_in, log_ready=1, binary order:
  - Signature after vectors 0..3 is 0x0000, 0x0003, 0x0003, 0x0000.
  - done=1 after 64 cycles, vec_count=32.
  - Final signature matches the software MISR model.
- gray_mode=1: logged pattern sequence starts 00000, 00001, 00011, 00010, 00110, ... and all 32 patterns appear exactly once.
- SETTLE_CYC=3 with DUT = 2-cycle register of parity: every logged response equals the parity of log_pattern. Repeat with SETTLE_CYC=1 and expect mismatches.
- Backpressure: log_ready low for 3 cycles in CAPTURE of vector 5 -> log_valid stays 1, log_pattern=00101, dut_in unchanged. The sweep completes in 67 cycles.
- abort during APPLY of vector 10: busy=0 next cycle, done=0, vec_count=10, dut_in=0. A later start sweeps cleanly from 0.
- reset asserted mid-CAPTURE and start pulsed while busy: all outputs go to 0 asynchronously, and the start pulsed while busy does not restart the sweep.
